// File: rtl/ps2_key_event_decoder_if.sv
// Key-event stream from the PS/2 event decoder to the game controller.
// The decoder drives the head-of-FIFO event; the consumer answers with ready.
interface ps2_key_event_decoder_if;
  logic       event_valid;
  logic       event_ready;
  logic [7:0] event_code;
  logic       event_ext;
  logic       event_break;

  modport master (
    output event_valid,
    output event_code,
    output event_ext,
    output event_break,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_code,
    input  event_ext,
    input  event_break,
    output event_ready
  );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 key event decoder.
// Turns the raw scan-code byte stream into single key events (E0/F0 prefixes
// folded into ext/break flags), tracks held state of the game keys, and
// queues events in a small first-word-fall-through FIFO.
module ps2_key_event_decoder #(
  parameter int FIFO_DEPTH    = 4,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         valid_scan_code,
  input  logic [7:0]                   scan_code,
  ps2_key_event_decoder_if.master      evt,
  output logic                         key_up,
  output logic                         key_down,
  output logic                         key_left,
  output logic                         key_right,
  output logic                         key_space,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam int         CNT_W    = PTR_W + 1;
  localparam logic [2:0] CAP_LAST = 3'(CAPTURE_DELAY);

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  // Keyboard status/ack bytes that never become key events outside a sequence.
  function automatic logic is_status_byte(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_status_byte = 1'b1;
      default:                                  is_status_byte = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0/p1: edge detect on valid_scan_code and delayed byte capture
  // ---------------------------------------------------------------------------
  logic       valid_p0;
  logic       valid_p1;
  logic       rise;
  logic       pending;
  logic [2:0] cap_cnt;
  logic       sample;
  logic       byte_rdy;
  logic [7:0] byte_p1;

  assign rise   = valid_p0 & ~valid_p1;
  assign sample = pending & ~rise & (cap_cnt == CAP_LAST);

  // Edge detector and capture counter; a fresh rise restarts any pending capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_p0 <= 1'b0;
      valid_p1 <= 1'b0;
      pending  <= 1'b0;
      cap_cnt  <= 3'd0;
      byte_rdy <= 1'b0;
    end else begin
      valid_p0 <= valid_scan_code;
      valid_p1 <= valid_p0;
      byte_rdy <= sample;
      if (rise) begin
        pending <= 1'b1;
        cap_cnt <= 3'd1;
      end else if (sample) begin
        pending <= 1'b0;
      end else if (pending) begin
        cap_cnt <= cap_cnt + 3'd1;
      end
    end
  end

  // Capture the byte once it has had time to settle upstream.
  always_ff @(posedge clk) begin
    if (sample) byte_p1 <= scan_code;
  end

  // ---------------------------------------------------------------------------
  // Stage p2: prefix parser, held-key tracking, event emit
  // ---------------------------------------------------------------------------
  state_t state;
  state_t next_state;
  logic   emit;
  logic   emit_ext;
  logic   emit_brk;

  // Next-state and emit decode for the prefix sequence parser.
  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    if (byte_rdy) begin
      case (state)
        IDLE: begin
          if (byte_p1 == PFX_EXT)      next_state = EXT;
          else if (byte_p1 == PFX_BRK) next_state = BRK;
          else if (!is_status_byte(byte_p1)) emit = 1'b1;
        end
        EXT: begin
          if (byte_p1 == PFX_BRK)      next_state = EXT_BRK;
          else if (byte_p1 == PFX_EXT) next_state = EXT;
          else begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            next_state = IDLE;
          end
        end
        BRK: begin
          // A break prefix followed by E0 is malformed: restart as extended.
          if (byte_p1 == PFX_EXT)      next_state = EXT;
          else if (byte_p1 == PFX_BRK) next_state = BRK;
          else begin
            emit       = 1'b1;
            emit_brk   = 1'b1;
            next_state = IDLE;
          end
        end
        default: begin
          if (byte_p1 == PFX_EXT)      next_state = EXT;
          else if (byte_p1 == PFX_BRK) next_state = EXT_BRK;
          else begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            emit_brk   = 1'b1;
            next_state = IDLE;
          end
        end
      endcase
    end
  end

  // Parser state and held-key bits; keys follow every event, FIFO full or not.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      key_up    <= 1'b0;
      key_down  <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
      key_space <= 1'b0;
    end else begin
      state <= next_state;
      if (emit) begin
        if (emit_ext) begin
          case (byte_p1)
            8'h75:   key_up    <= ~emit_brk;
            8'h72:   key_down  <= ~emit_brk;
            8'h6B:   key_left  <= ~emit_brk;
            8'h74:   key_right <= ~emit_brk;
            default: ;
          endcase
        end else if (byte_p1 == 8'h29) begin
          key_space <= ~emit_brk;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             not_empty;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic [9:0]       head;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = not_empty & evt.event_ready;
  // When full, a pop in the same cycle frees the slot the push lands in.
  assign push_ok   = emit & (~full | pop);
  assign drop      = emit & full & ~pop;
  assign head      = mem[rd_ptr];

  // FIFO pointers, occupancy and the sticky overflow flag (a drop beats a clear).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // FIFO storage, written with {break, ext, code}.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {emit_brk, emit_ext, byte_p1};
  end

  // Head fields are forced to zero while the FIFO is empty.
  assign evt.event_valid = not_empty;
  assign evt.event_code  = not_empty ? head[7:0] : 8'h00;
  assign evt.event_ext   = not_empty & head[8];
  assign evt.event_break = not_empty & head[9];

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Self-checking bench for ps2_key_event_decoder: table of scan bytes with
// expected events/key state, a scoreboard queue for FIFO output, and
// hand-written sequences for latency, overflow and reset corner cases.
module tb_ps2_key_event_decoder;
  localparam int CD    = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid_scan_code = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       clr_overflow = 1'b0;
  logic       key_up, key_down, key_left, key_right, key_space, overflow;
  logic [4:0] keys_now;

  ps2_key_event_decoder_if evt ();

  ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH), .CAPTURE_DELAY(CD)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .valid_scan_code (valid_scan_code),
    .scan_code       (scan_code),
    .evt             (evt),
    .key_up          (key_up),
    .key_down        (key_down),
    .key_left        (key_left),
    .key_right       (key_right),
    .key_space       (key_space),
    .overflow        (overflow),
    .clr_overflow    (clr_overflow)
  );

  always #5 clk = ~clk;

  assign keys_now = {key_up, key_down, key_left, key_right, key_space};

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  typedef struct packed {
    logic [7:0] code;
    logic       emit;
    logic       ext;
    logic       brk;
    logic [4:0] keys;  // {up, down, left, right, space} after the byte
  } vec_t;

  ev_t  exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted head event must match the oldest expectation.
  always @(negedge clk) begin
    ev_t e;
    if (reset_n && evt.event_valid && evt.event_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h/%0b/%0b expected none",
                 evt.event_code, evt.event_ext, evt.event_break);
      end else begin
        e = exp_q.pop_front();
        chk("event", {22'd0, evt.event_code, evt.event_ext, evt.event_break},
            {22'd0, e.code, e.ext, e.brk});
      end
    end
  end

  task automatic push_exp(input logic [7:0] c, input logic x, input logic b);
    ev_t e;
    e.code = c;
    e.ext  = x;
    e.brk  = b;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 valid_scan_code = 1'b1;
    scan_code = b;
    repeat (CD + 4) @(posedge clk);
    #1 valid_scan_code = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Sends one byte and drives ready/clr only during the cycle its event is written.
  task automatic send_timed(input logic [7:0] b, input logic r, input logic c);
    @(posedge clk);
    #1 valid_scan_code = 1'b1;
    scan_code = b;
    repeat (CD + 2) @(posedge clk);
    #1 evt.event_ready = r;
    clr_overflow = c;
    @(posedge clk);
    #1 evt.event_ready = 1'b0;
    clr_overflow = 1'b0;
    @(negedge clk);
    valid_scan_code = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_overflow = 1'b1;
    @(posedge clk);
    #1 clr_overflow = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{8'h1C, 1'b1, 1'b0, 1'b0, 5'b00000},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b00000},
      '{8'h75, 1'b1, 1'b1, 1'b0, 5'b10000},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b10000},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 5'b10000},
      '{8'h75, 1'b1, 1'b1, 1'b1, 5'b00000},
      '{8'hAA, 1'b0, 1'b0, 1'b0, 5'b00000},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 5'b00000},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b00000},
      '{8'h6B, 1'b1, 1'b1, 1'b0, 5'b00100},
      '{8'h29, 1'b1, 1'b0, 1'b0, 5'b00101},
      '{8'h29, 1'b1, 1'b0, 1'b0, 5'b00101},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 5'b00101},
      '{8'h29, 1'b1, 1'b0, 1'b1, 5'b00100},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b00100},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 5'b00100},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b00100},
      '{8'h72, 1'b1, 1'b1, 1'b0, 5'b01100},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b01100},
      '{8'h74, 1'b1, 1'b1, 1'b0, 5'b01110},
      '{8'hFA, 1'b0, 1'b0, 1'b0, 5'b01110},
      '{8'h00, 1'b0, 1'b0, 1'b0, 5'b01110},
      '{8'hFF, 1'b0, 1'b0, 1'b0, 5'b01110},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b01110},
      '{8'hFA, 1'b1, 1'b1, 1'b0, 5'b01110},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b01110},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 5'b01110},
      '{8'h6B, 1'b1, 1'b1, 1'b1, 5'b01010},
      '{8'hF0, 1'b0, 1'b0, 1'b0, 5'b01010},
      '{8'h74, 1'b1, 1'b0, 1'b1, 5'b01010},
      '{8'hEE, 1'b0, 1'b0, 1'b0, 5'b01010},
      '{8'hFE, 1'b0, 1'b0, 1'b0, 5'b01010},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b01010},
      '{8'hE0, 1'b0, 1'b0, 1'b0, 5'b01010},
      '{8'h74, 1'b1, 1'b1, 1'b0, 5'b01010}
    };

    evt.event_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", evt.event_valid, 0);
    chk("rst_code", evt.event_code, 0);
    chk("rst_flags", {evt.event_ext, evt.event_break}, 0);
    chk("rst_keys", keys_now, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Latency: rise at edge E, event visible after edge E+CD+2
    @(posedge clk);
    #1 valid_scan_code = 1'b1;
    scan_code = 8'h1C;
    push_exp(8'h1C, 1'b0, 1'b0);
    @(posedge clk);
    repeat (CD + 1) @(posedge clk);
    @(negedge clk);
    chk("lat_early", evt.event_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", evt.event_valid, 1);
    chk("lat_head", {evt.event_code, evt.event_ext, evt.event_break}, {8'h1C, 2'b00});
    valid_scan_code = 1'b0;
    @(posedge clk);
    #1 evt.event_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("lat_popped", evt.event_valid, 0);

    // Table of byte-by-byte vectors, consumer always ready
    foreach (tbl[i]) begin
      if (tbl[i].emit) push_exp(tbl[i].code, tbl[i].ext, tbl[i].brk);
      send_byte(tbl[i].code);
      @(negedge clk);
      chk($sformatf("keys_row%0d", i), keys_now, tbl[i].keys);
    end
    wait_drain("table_drain");

    // Overflow: fill with ready low, fifth make is dropped
    @(posedge clk);
    #1 evt.event_ready = 1'b0;
    push_exp(8'h15, 1'b0, 1'b0); send_byte(8'h15);
    push_exp(8'h1D, 1'b0, 1'b0); send_byte(8'h1D);
    push_exp(8'h24, 1'b0, 1'b0); send_byte(8'h24);
    push_exp(8'h2D, 1'b0, 1'b0); send_byte(8'h2D);
    @(negedge clk);
    chk("full_no_ovf", overflow, 0);
    send_byte(8'h2C);
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    pulse_clr();
    @(negedge clk);
    chk("ovf_clr", overflow, 0);
    // A drop coinciding with clr_overflow leaves the flag set
    send_timed(8'h3C, 1'b0, 1'b1);
    chk("ovf_drop_beats_clr", overflow, 1);
    pulse_clr();
    @(negedge clk);
    chk("ovf_clr2", overflow, 0);
    @(posedge clk);
    #1 evt.event_ready = 1'b1;
    wait_drain("ovf_drain");

    // Full FIFO with a pop in the same cycle as a push
    @(posedge clk);
    #1 evt.event_ready = 1'b0;
    push_exp(8'h16, 1'b0, 1'b0); send_byte(8'h16);
    push_exp(8'h1E, 1'b0, 1'b0); send_byte(8'h1E);
    push_exp(8'h26, 1'b0, 1'b0); send_byte(8'h26);
    push_exp(8'h25, 1'b0, 1'b0); send_byte(8'h25);
    push_exp(8'h2E, 1'b0, 1'b0);
    send_timed(8'h2E, 1'b1, 1'b0);
    chk("pushpop_no_ovf", overflow, 0);
    chk("pushpop_valid", evt.event_valid, 1);
    // Still holding four entries: one more push must be dropped
    send_byte(8'h36);
    @(negedge clk);
    chk("pushpop_still_full", overflow, 1);
    pulse_clr();
    @(posedge clk);
    #1 evt.event_ready = 1'b1;
    wait_drain("pushpop_drain");

    // Reset in the middle of an E0 sequence discards the prefix
    send_byte(8'hE0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_keys", keys_now, 0);
    chk("midrst_valid", evt.event_valid, 0);
    push_exp(8'h29, 1'b0, 1'b0);
    send_byte(8'h29);
    @(negedge clk);
    chk("midrst_space", keys_now, 5'b00001);
    wait_drain("midrst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
- Sits directly downstream of the PS/2 serial-to-scancode stage; consumes its `valid_scan_code` level and `scan_code` byte.
- Parses PS/2 set-2 prefix sequences (E0 extended, F0 break) into single key events and buffers them in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake.
- Maintains a held-state bit for each game control key: arrows and space.
- Feeds the game controller logic.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
- CAPTURE_DELAY, 2, clk cycles between the rising edge of `valid_scan_code` and sampling of `scan_code`; range 1..7.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- valid_scan_code  in  1  level from the upstream stage; a rising edge marks a new byte
- scan_code  in  8  byte from the upstream stage; stable from CAPTURE_DELAY cycles after the rise
- event_valid  out  1  FIFO head holds an event
- event_ready  in  1  consumer accepts the head
- event_code  out  8  key code of the head event, with no prefix
- event_ext  out  1  head event was E0-prefixed
- event_break  out  1  head event is a release (1) or a press (0)
- key_up  out  1  held state of E0 75
- key_down  out  1  held state of E0 72
- key_left  out  1  held state of E0 6B
- key_right  out  1  held state of E0 74
- key_space  out  1  held state of 29, non-extended
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full
- clr_overflow  in  1  clears `overflow`

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk.
  - All outputs go to 0, the FIFO empties and the FSM returns to IDLE.
  - Any pending capture is cancelled.
  - Reset mid-sequence (e.g. after E0) discards the partial sequence.
- Edge detect:
  - Register `valid_scan_code`; rise = current 1 and previous 0.
  - A rise starts a capture counter. At the edge where the counter reaches CAPTURE_DELAY, `scan_code` is sampled and `byte_rdy` pulses for one cycle.
  - A new rise while a capture is pending restarts the counter; the pending byte is discarded.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions on `byte_rdy`:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - AA, FA, EE, FE, 00, FF -> dropped, stay in IDLE.
    - Any other byte X -> emit {X, ext=0, brk=0}, stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> EXT.
    - X -> emit {X, 1, 0}, go to IDLE.
  - BRK:
    - E0 -> EXT; malformed sequence, restart.
    - F0 -> BRK.
    - X -> emit {X, 0, 1}, go to IDLE.
  - EXT_BRK:
    - E0 -> EXT.
    - F0 -> EXT_BRK.
    - X -> emit {X, 1, 1}, go to IDLE.
- Emit timing:
  - FSM state, key bits and FIFO write all update at the edge after `byte_rdy`.
  - Latency from the rise of `valid_scan_code` (edge E) to `event_valid` (FIFO previously empty) is CAPTURE_DELAY + 2 edges.
- Held keys:
  - A matching make sets the bit; a matching break clears it.
  - A make of an already-held key keeps it at 1 (typematic).
  - Key bits update even when the FIFO is full.
- FIFO:
  - FWFT: `event_*` outputs reflect the head whenever `event_valid` is 1.
  - Pop when `event_valid` and `event_ready` are both 1.
  - `event_ready` while empty has no effect.
  - Push while full with no pop in the same cycle: the new event is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both occur and the count is unchanged.
  - Push and pop in the same cycle while empty: no pop; the push lands.
  - Pointers are log2(FIFO_DEPTH) bits and wrap; a count register of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Overflow flag:
  - `clr_overflow` clears `overflow`.
  - A drop in the same cycle as `clr_overflow` wins: `overflow` = 1.

Test Plan:
- Byte 1C (rise, then byte after 2 clk) -> `event_valid` at edge E+4, `event_code`=1C, `event_ext`=0, `event_break`=0; `event_ready`=1 -> `event_valid`=0 next cycle.
- Sequence E0 75, then E0 F0 75 -> `key_up` 0->1 after the 75 byte, 1->0 after the final 75; FIFO holds {75,1,0} then {75,1,1}.
- `event_ready`=0, 5 make codes 15,1D,24,2D,2C with FIFO_DEPTH=4 -> FIFO holds 15,1D,24,2D in order; 2C dropped; `overflow`=1; `clr_overflow` -> 0.
- FIFO full with `event_ready`=1 in the same cycle as a new push -> count stays 4, no overflow, order preserved.
- Bytes E0 then reset_n=0 for 1 cycle, then 29 -> event {29,0,0} and `key_space`=1 (the E0 prefix was discarded).
- Bytes AA, F0 E0 6B -> no event for AA; event {6B,1,0} (malformed break restarted as extended); `key_left`=1.
